// File: rtl/axi4_slave_mem.sv
// AXI4 memory slave: word-addressed RAM behind independent write (AW/W/B) and read (AR/R) engines.
// Build macro AXI_SLV_ERR_CHK_EN enables SLVERR responses for out-of-range, reserved or illegal bursts.
module axi4_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [ID_WIDTH-1:0]     RID,
  output logic                    RLAST,
  output logic [1:0]              RRESP
);
  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(STRB_W);
  localparam int IDX_BITS  = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
`ifdef AXI_SLV_ERR_CHK_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_W);
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [2:0] eff_size(input logic [2:0] size);
    return (size > 3'(LANE_BITS)) ? 3'(LANE_BITS) : size;
  endfunction

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // WRAP with an unsupported length falls back to INCR stepping
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] bytes, aligned, span;
    bytes   = ADDR_WIDTH'(1) << eff_size(size);
    aligned = addr & ~(bytes - ADDR_WIDTH'(1));
    case (len[3:0])
      4'd1:    span = bytes << 1;
      4'd3:    span = bytes << 2;
      4'd7:    span = bytes << 3;
      default: span = bytes << 4;
    endcase
    if (burst == BURST_FIXED)
      return addr;
    else if (burst == BURST_WRAP && wrap_len_ok(len))
      return (addr & ~(span - ADDR_WIDTH'(1))) | ((aligned + bytes) & (span - ADDR_WIDTH'(1)));
    else
      return aligned + bytes;
  endfunction

  function automatic logic [IDX_BITS-1:0] ram_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[LANE_BITS +: IDX_BITS];
  endfunction

  function automatic logic [STRB_W-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] addr,
                                                  input logic [2:0] size);
    logic [STRB_W-1:0] m;
    int lo, n;
    lo = int'(addr[LANE_BITS-1:0]);
    n  = 1 << eff_size(size);
    for (int i = 0; i < STRB_W; i++) m[i] = (i >= lo) && (i < lo + n);
    return m;
  endfunction

  function automatic logic beat_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
`ifdef AXI_SLV_ERR_CHK_EN
    return ({1'b0, addr} >= MEM_BYTES) || (burst == 2'b11) || (size > 3'(LANE_BITS)) ||
           (burst == BURST_WRAP && !wrap_len_ok(len));
`else
    return 1'b0;
`endif
  endfunction

  logic alive;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) alive <= 1'b0;
    else      alive <= 1'b1;
  end

  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            aw_len_q, w_cnt;
  logic [2:0]            aw_size_q;
  logic [1:0]            aw_burst_q, bresp_q;
  logic                  w_bad, aw_fire, w_fire, w_last_beat, w_err;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [STRB_W-1:0]     w_lanes;
  logic [IDX_BITS-1:0]   w_idx;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = alive;
        if (AWVALID && alive) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_fire     = AWVALID && AWREADY;
  assign w_fire      = WVALID && WREADY;
  assign w_last_beat = (w_cnt == aw_len_q);
  assign w_err       = beat_err(w_addr, aw_len_q, aw_size_q, aw_burst_q);
  assign w_lanes     = lane_mask(w_addr, aw_size_q);
  assign w_idx       = ram_idx(w_addr);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      aw_id_q    <= '0;
      w_addr     <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt      <= '0;
      w_bad      <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else if (aw_fire) begin
      aw_id_q    <= AWID;
      w_addr     <= AWADDR;
      aw_len_q   <= AWLEN;
      aw_size_q  <= AWSIZE;
      aw_burst_q <= AWBURST;
      w_cnt      <= '0;
      w_bad      <= 1'b0;
    end else if (w_fire) begin
      w_addr <= next_addr(w_addr, aw_len_q, aw_size_q, aw_burst_q);
      w_cnt  <= w_cnt + 8'd1;
      // an early WLAST or a missing final WLAST both poison the response
      if (w_last_beat)
        bresp_q <= (w_bad || w_err || !WLAST) ? RESP_SLVERR : RESP_OKAY;
      else if (w_err || WLAST)
        w_bad <= 1'b1;
    end
  end

  always_comb begin
    w_merged = mem[w_idx];
    for (int i = 0; i < STRB_W; i++)
      if (w_lanes[i] && WSTRB[i]) w_merged[8*i +: 8] = WDATA[8*i +: 8];
  end

  always_ff @(posedge CLK) begin
    if (w_fire && !w_err) mem[w_idx] <= w_merged;
  end

  assign BID   = aw_id_q;
  assign BRESP = bresp_q;

  r_state_t              r_state, r_next;
  logic [ID_WIDTH-1:0]   ar_id_q;
  logic [ADDR_WIDTH-1:0] r_addr, r_step, fetch_addr;
  logic [7:0]            ar_len_q, r_cnt;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ar_fire, r_fire, r_last, fetch_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = alive;
        if (ARVALID && alive) r_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_fire = ARVALID && ARREADY;
  assign r_fire  = RVALID && RREADY;
  assign r_last  = (r_cnt == ar_len_q);

  // the word for the next presented beat is fetched into a register so it cannot change while stalled
  always_comb begin
    r_step = next_addr(r_addr, ar_len_q, ar_size_q, ar_burst_q);
    if (ar_fire) begin
      fetch_addr = ARADDR;
      fetch_err  = beat_err(ARADDR, ARLEN, ARSIZE, ARBURST);
    end else begin
      fetch_addr = r_step;
      fetch_err  = beat_err(r_step, ar_len_q, ar_size_q, ar_burst_q);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ar_id_q    <= '0;
      r_addr     <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else if (ar_fire || (r_fire && !r_last)) begin
      if (ar_fire) begin
        ar_id_q    <= ARID;
        ar_len_q   <= ARLEN;
        ar_size_q  <= ARSIZE;
        ar_burst_q <= ARBURST;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      r_addr  <= fetch_addr;
      rdata_q <= fetch_err ? '0 : mem[ram_idx(fetch_addr)];
      rresp_q <= fetch_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign RDATA = rdata_q;
  assign RID   = ar_id_q;
  assign RRESP = rresp_q;
  assign RLAST = RVALID && r_last;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem: directed AXI4 scenarios plus randomized bursts
// checked against a byte-array reference memory with burst addressing computed arithmetically.
module tb_axi4_slave_mem;
  localparam int DEPTH     = 1024;
  localparam int MEM_BYTES = DEPTH * 4;

  logic        CLK = 1'b0, RST = 1'b0;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [3:0]  AWID, BID, ARID, RID, WSTRB;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;

  int n_cmp = 0, n_bad = 0;
  byte unsigned ref_mem [MEM_BYTES];
  logic [31:0] wdata_q[$];
  logic [3:0]  wstrb_q[$];
  logic [31:0] rd_q[$];

  axi4_slave_mem dut (
    .CLK(CLK), .RST(RST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID), .RLAST(RLAST), .RRESP(RRESP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint m_bytes(input int size);
    return (size >= 2) ? 4 : (longint'(1) << size);
  endfunction

  function automatic bit m_err(input longint addr, input int len, input int size, input int burst);
`ifdef AXI_SLV_ERR_CHK_EN
    return (addr >= MEM_BYTES) || (burst == 3) || (size > 2) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
`else
    return 1'b0;
`endif
  endfunction

  function automatic longint m_addr(input longint start, input int len, input int size,
                                    input int burst, input int i);
    longint bytes, al, bnd, base;
    bytes = m_bytes(size);
    al    = (start / bytes) * bytes;
    if (i == 0 || burst == 0) return start;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      bnd  = (len + 1) * bytes;
      base = (start / bnd) * bnd;
      return base + ((al - base + i * bytes) % bnd);
    end
    return al + i * bytes;
  endfunction

  function automatic logic [31:0] m_word(input longint addr);
    int idx;
    idx = int'((addr / 4) % DEPTH);
    return {ref_mem[idx*4+3], ref_mem[idx*4+2], ref_mem[idx*4+1], ref_mem[idx*4]};
  endfunction

  task automatic m_write(input longint addr, input int size, input logic [31:0] data,
                         input logic [3:0] strb);
    int idx, lo, n;
    idx = int'((addr / 4) % DEPTH);
    lo  = int'(addr % 4);
    n   = int'(m_bytes(size));
    for (int l = 0; l < 4; l++)
      if (l >= lo && l < lo + n && strb[l]) ref_mem[idx*4+l] = data[8*l +: 8];
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done, hs;
    int t;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    done = 1'b0; t = 0;
    while (!done && t < 20) begin
      hs = AWREADY;
      @(posedge CLK); #1;
      done = hs; t++;
    end
    AWVALID = 1'b0;
    check("aw_handshake", done, 1);
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done, hs;
    int t;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    done = 1'b0; t = 0;
    while (!done && t < 20) begin
      hs = ARREADY;
      @(posedge CLK); #1;
      done = hs; t++;
    end
    ARVALID = 1'b0;
    check("ar_handshake", done, 1);
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input int gap);
    WVALID = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    check("wready", WREADY, 1);
    @(posedge CLK); #1;
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  // wlast_mode: 0 correct, 1 early WLAST on beat 0, 2 WLAST missing on the final beat
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int wlast_mode, input int bdelay);
    bit exp_bad, last;
    longint a;
    exp_bad = 1'b0;
    aw_send(id, addr, 8'(len), 3'(size), 2'(burst));
    for (int i = 0; i <= len; i++) begin
      a    = m_addr(addr, len, size, burst, i);
      last = (i == len);
      if (wlast_mode == 1 && i == 0 && len > 0) begin last = 1'b1; exp_bad = 1'b1; end
      if (wlast_mode == 2 && i == len) begin last = 1'b0; exp_bad = 1'b1; end
      if (m_err(a, len, size, burst)) exp_bad = 1'b1;
      else m_write(a, size, wdata_q[i], wstrb_q[i]);
      w_beat(wdata_q[i], wstrb_q[i], last, int'($urandom_range(0, 1)));
    end
    check("bvalid", BVALID, 1);
    repeat (bdelay) begin
      @(posedge CLK); #1;
      check("b_hold_valid", BVALID, 1);
      check("b_hold_id", BID, id);
      check("b_hold_resp", BRESP, exp_bad ? 2'b10 : 2'b00);
    end
    BREADY = 1'b1;
    check("bid", BID, id);
    check("bresp", BRESP, exp_bad ? 2'b10 : 2'b00);
    @(posedge CLK); #1;
    BREADY = 1'b0;
    check("b_done", BVALID, 0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int stall_beat, input int stall_cyc);
    longint a;
    bit e;
    logic [31:0] exp_d;
    rd_q.delete();
    ar_send(id, addr, 8'(len), 3'(size), 2'(burst));
    RREADY = 1'b1;
    for (int i = 0; i <= len; i++) begin
      a     = m_addr(addr, len, size, burst, i);
      e     = m_err(a, len, size, burst);
      exp_d = e ? 32'h0 : m_word(a);
      if (i == stall_beat) begin
        RREADY = 1'b0;
        repeat (stall_cyc) begin
          check("r_hold_valid", RVALID, 1);
          check("r_hold_data", RDATA, exp_d);
          check("r_hold_last", RLAST, i == len);
          @(posedge CLK); #1;
        end
        RREADY = 1'b1;
      end
      check("rvalid", RVALID, 1);
      check("rdata", RDATA, exp_d);
      check("rid", RID, id);
      check("rresp", RRESP, e ? 2'b10 : 2'b00);
      check("rlast", RLAST, i == len);
      rd_q.push_back(RDATA);
      @(posedge CLK); #1;
    end
    RREADY = 1'b0;
    check("r_end_valid", RVALID, 0);
    check("r_end_arready", ARREADY, 1);
  endtask

  initial begin
    int lens[4];
    int burst, size, len, bytes, wm;
    logic [31:0] addr;
    lens = '{1, 3, 7, 15};
    AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
    ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; RREADY = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_awready", AWREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_outs", {BID, BRESP, RDATA, RID, RLAST, RRESP}, 0);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_awready", AWREADY, 1);
    check("post_rst_arready", ARREADY, 1);

    // fill the whole RAM with 256-beat INCR bursts so every later read is defined
    for (int blk = 0; blk < 4; blk++) begin
      wdata_q.delete(); wstrb_q.delete();
      for (int j = 0; j < 256; j++) begin wdata_q.push_back($urandom); wstrb_q.push_back(4'hF); end
      axi_write(4'(blk), 32'(blk * 1024), 255, 2, 1, 0, 0);
    end

    wdata_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    wstrb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'h1, 32'h10, 3, 2, 1, 0, 0);
    axi_read(4'h2, 32'h10, 3, 2, 1, -1, 0);
    check("incr_data", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, {32'hA0, 32'hA1, 32'hA2, 32'hA3});
    axi_read(4'h3, 32'h18, 3, 2, 2, -1, 0);
    check("wrap_data", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, {32'hA2, 32'hA3, 32'hA0, 32'hA1});

    wdata_q = '{32'hFFFF_FFFF}; wstrb_q = '{4'hF};
    axi_write(4'h4, 32'h40, 0, 2, 1, 0, 0);
    wdata_q = '{32'h1234_5678}; wstrb_q = '{4'h5};
    axi_write(4'h5, 32'h40, 0, 2, 1, 0, 0);
    axi_read(4'h6, 32'h40, 0, 2, 1, -1, 0);
    check("strobe_data", rd_q[0], 32'hFF34_FF78);

    wdata_q.delete(); wstrb_q.delete();
    for (int j = 0; j < 6; j++) begin wdata_q.push_back($urandom); wstrb_q.push_back(4'hF); end
    axi_write(4'h7, 32'h300, 5, 2, 1, 0, 5);
    axi_read(4'h8, 32'h300, 5, 2, 1, 2, 3);

    axi_write(4'h9, 32'h80, 2, 2, 1, 1, 0);
    axi_write(4'hA, 32'h90, 2, 2, 1, 2, 1);
    axi_read(4'h9, 32'h80, 7, 2, 1, -1, 0);

    wdata_q = '{32'h5555_0001, 32'h5555_0002}; wstrb_q = '{4'hF, 4'hF};
    axi_write(4'hB, 32'hA0, 1, 2, 3, 0, 0);
    axi_read(4'hC, 32'hA0, 1, 2, 3, -1, 0);
`ifdef AXI_SLV_ERR_CHK_EN
    check("burst3_data", {rd_q[0], rd_q[1]}, 64'h0);
`else
    check("burst3_data", {rd_q[0], rd_q[1]}, {32'h5555_0001, 32'h5555_0002});
`endif

    // reset while beat 2 of a 4-beat write is on the bus
    aw_send(4'hD, 32'h200, 3, 2, 1);
    w_beat(32'hC0DE_0000, 4'hF, 1'b0, 0); m_write(32'h200, 2, 32'hC0DE_0000, 4'hF);
    w_beat(32'hC0DE_0001, 4'hF, 1'b0, 0); m_write(32'h204, 2, 32'hC0DE_0001, 4'hF);
    WDATA = 32'hC0DE_0002; WSTRB = 4'hF; WVALID = 1'b1;
    RST = 1'b0;
    #1;
    check("midrst_wready", WREADY, 0);
    check("midrst_bvalid", BVALID, 0);
    check("midrst_rvalid", RVALID, 0);
    check("midrst_awready", AWREADY, 0);
    WVALID = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;
    check("midrst_after_awready", AWREADY, 1);
    check("midrst_after_bvalid", BVALID, 0);
    axi_read(4'hE, 32'h200, 3, 2, 1, -1, 0);
    check("midrst_kept", {rd_q[0], rd_q[1]}, {32'hC0DE_0000, 32'hC0DE_0001});

    for (int it = 0; it < 40; it++) begin
      burst = int'($urandom_range(0, 2));
      size  = int'($urandom_range(0, 2));
      len   = (burst == 2) ? lens[$urandom_range(0, 3)] : int'($urandom_range(0, 7));
      bytes = 1 << size;
      addr  = 32'($urandom_range(0, MEM_BYTES - 65)) & ~32'(bytes - 1);
      wm    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      wdata_q.delete(); wstrb_q.delete();
      for (int j = 0; j <= len; j++) begin wdata_q.push_back($urandom); wstrb_q.push_back(4'($urandom)); end
      axi_write(4'($urandom), addr, len, size, burst, wm, int'($urandom_range(0, 3)));
      axi_read(4'($urandom), addr, len, size, burst, int'($urandom_range(0, len)),
               int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
